inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter: col, default 8, PE array columns and weight rows per kij.
REQ-002 Parameter: row, default 8, PE array rows, used for the execute drain length.
REQ-003 Parameter: len_nij, default 36, activation words per pass, 6x6 input.
REQ-004 Parameter: len_kij, default 9, kernel positions, 3x3 kernel.
REQ-005 Parameter: len_onij, default 16, output pixels, 4x4 output.
REQ-006 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-007 Port: reset  input  1  asynchronous, active-low reset.
REQ-008 Port: start  input  1  begin a full convolution run; sampled only in IDLE.
REQ-009 Port: ofifo_valid  input  1  core OFIFO holds a complete output row.
REQ-010 Port: inst  output  34  core instruction word, with the bit map below.
REQ-011 inst bit map: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-012 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-013 Port: done  output  1  one-cycle pulse at run completion.
REQ-014 Port: out_valid  output  1  one-cycle pulse when an accumulated output is complete in the core.
REQ-015 Port: onij  output  4  index of the output flagged by out_valid.

Function
REQ-016 All outputs are registered; inst changes only on the rising edge of clk.
REQ-017 Idle word: CEN_xmem=1, WEN_xmem=1, CEN_pmem=1, WEN_pmem=1, all other fields 0; inst equals the idle word outside active phases.
REQ-018 ififo_wr and ififo_rd are held at 0 at all times.
REQ-019 States: IDLE, W_L0, W_LOAD, A_L0, EXEC, DRAIN, O_PMEM, NEXT, ACC_RD, ACC_GAP, DONE.
REQ-020 Counters: kij 0..len_kij-1, onij 0..len_onij-1, cycle counter cnt, pmem write pointer wp (11 bits).
REQ-021 IDLE to W_L0 on start=1; kij=0, wp=0.
REQ-022 W_L0 runs col cycles with CEN_xmem=0, WEN_xmem=1, l0_wr=1, and A_xmem=1024+kij*col+cnt.
REQ-023 W_LOAD runs col cycles with l0_rd=1 and load=1, followed by 2 idle cycles.
REQ-024 A_L0 runs len_nij cycles with CEN_xmem=0, WEN_xmem=1, l0_wr=1, and A_xmem=cnt, followed by 2 idle cycles.
REQ-025 EXEC runs len_nij cycles with l0_rd=1 and execute=1.
REQ-026 DRAIN runs row+col cycles with l0_rd=1 and execute=1, then 1 idle cycle.
REQ-027 O_PMEM: while ofifo_valid=1, drive ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=wp, and increment wp.
REQ-028 O_PMEM: while ofifo_valid=0, drive the idle word and hold the count (stall).
REQ-029 O_PMEM exits after len_nij writes.
REQ-030 NEXT: if kij<len_kij-1, increment kij and go to W_L0; otherwise set onij=0 and go to ACC_RD.
REQ-031 ACC_RD runs len_kij+1 cycles; for j<len_kij it drives CEN_pmem=0, WEN_pmem=1, A_pmem=j*len_nij+(onij/4+j/3)*6+(onij%4+j%3).
REQ-032 ACC_RD drives acc=1 for j>=1 and CEN_pmem=1 at j=len_kij.
REQ-033 ACC_GAP is one cycle with the idle word and out_valid=1 for the current onij.
REQ-034 After ACC_GAP, go to ACC_RD with onij+1, or to DONE after onij=len_onij-1.
REQ-035 DONE pulses done=1 for one cycle, drops busy, and returns to IDLE.
REQ-036 start while busy=1 is ignored, with no restart and no queueing.
REQ-037 Address arithmetic is unsigned and 11-bit; len_kij*len_nij<=2048 and 1024+len_kij*col<=2048 are required, so no wrap occurs in legal configurations.
REQ-038 The O_PMEM stall count is unbounded, with no timeout.

Reset
REQ-039 reset=0 immediately forces IDLE from any state, including mid-phase.
REQ-040 On reset, inst takes the idle word; busy, done, and out_valid go to 0; onij, kij, cnt, and wp go to 0.
REQ-041 After reset is released, the block waits for a new start and does not resume the interrupted run.

Verification
REQ-042 Scenario: reset, then start pulse with ofifo_valid=1 -> W_L0 has 8 cycles with A_xmem 1024..1031; busy rises on the next cycle.
REQ-043 Scenario: full run with ofifo_valid=1 -> 9*36=324 pmem writes with A_pmem 0..323 contiguous; 16 out_valid pulses with onij 0..15; then a single done pulse.
REQ-044 Scenario: onij=5 accumulation -> A_pmem sequence 7, 44, 81, 121, 158, 195, 235, 272, 309, with acc high for 9 cycles starting one cycle after the first read.
REQ-045 Scenario: ofifo_valid low for 5 cycles mid-O_PMEM -> ofifo_rd=0 and CEN_pmem=1 for those cycles, and wp is unchanged and then resumes at the next address.
REQ-046 Scenario: reset asserted during EXEC at kij=3 -> inst equals the idle word and busy=0 immediately; a fresh start restarts at kij=0 with A_xmem=1024.
REQ-047 Scenario: start pulsed during ACC_RD -> no effect; sequence and done timing are identical to the undisturbed run.

Source files
------------

// File: rtl/inst_sequencer.sv
// Instruction sequencer for the convolution core: per kernel position it loads weights and
// activations, executes, writes psums to pmem, then reads pmem back to accumulate each output.
module inst_sequencer #(
    parameter int unsigned col      = 8,
    parameter int unsigned row      = 8,
    parameter int unsigned len_nij  = 36,
    parameter int unsigned len_kij  = 9,
    parameter int unsigned len_onij = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    output logic [3:0]  onij
);

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned CNT_MAX = len_nij + row + col + len_kij + 2;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned KIJ_W   = $clog2(len_kij + 1);
    localparam int unsigned ONIJ_W  = 4;
    localparam int unsigned W_BASE  = 1024;

    typedef struct packed {
        logic              acc;
        logic              cen_pmem;
        logic              wen_pmem;
        logic [ADDR_W-1:0] a_pmem;
        logic              cen_xmem;
        logic              wen_xmem;
        logic [ADDR_W-1:0] a_xmem;
        logic              ofifo_rd;
        logic              ififo_wr;
        logic              ififo_rd;
        logic              l0_rd;
        logic              l0_wr;
        logic              execute;
        logic              load;
    } inst_t;

    localparam inst_t IDLE_WORD = '{
        acc: 1'b0, cen_pmem: 1'b1, wen_pmem: 1'b1, a_pmem: 11'd0,
        cen_xmem: 1'b1, wen_xmem: 1'b1, a_xmem: 11'd0,
        ofifo_rd: 1'b0, ififo_wr: 1'b0, ififo_rd: 1'b0,
        l0_rd: 1'b0, l0_wr: 1'b0, execute: 1'b0, load: 1'b0
    };

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_L0,
        S_W_LOAD,
        S_A_L0,
        S_EXEC,
        S_DRAIN,
        S_O_PMEM,
        S_NEXT,
        S_ACC_RD,
        S_ACC_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [KIJ_W-1:0]    kij_q, kij_d;
    logic [ONIJ_W-1:0]   onij_q, onij_d;
    logic [ADDR_W-1:0]   wp_q, wp_d;
    inst_t               inst_q, inst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                out_valid_q, out_valid_d;
    logic [ONIJ_W-1:0]   onij_out_q, onij_out_d;

    logic [ADDR_W-1:0]   a_wl0;
    logic [ADDR_W-1:0]   a_acc;

    // Weight rows live above 1024 in xmem; psum read address walks the 3x3 window of a 6x6 tile.
    assign a_wl0 = ADDR_W'(32'(W_BASE) + 32'(kij_q) * col + 32'(cnt_q));
    assign a_acc = ADDR_W'(32'(cnt_q) * len_nij
                         + (32'(onij_q) / 32'd4 + 32'(cnt_q) / 32'd3) * 32'd6
                         + 32'(onij_q) % 32'd4 + 32'(cnt_q) % 32'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            kij_q       <= '0;
            onij_q      <= '0;
            wp_q        <= '0;
            inst_q      <= IDLE_WORD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            onij_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kij_q       <= kij_d;
            onij_q      <= onij_d;
            wp_q        <= wp_d;
            inst_q      <= inst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            onij_out_q  <= onij_out_d;
        end
    end

    // Next state, counters, and the instruction word registered for the following cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kij_d   = kij_q;
        onij_d  = onij_q;
        wp_d    = wp_q;
        inst_d  = IDLE_WORD;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_W_L0;
                    cnt_d   = '0;
                    kij_d   = '0;
                    onij_d  = '0;
                    wp_d    = '0;
                end
            end

            S_W_L0: begin
                inst_d.cen_xmem = 1'b0;
                inst_d.l0_wr    = 1'b1;
                inst_d.a_xmem   = a_wl0;
                if (cnt_q == CNT_W'(col - 1)) begin
                    cnt_d   = '0;
                    state_d = S_W_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // col load cycles, then two idle cycles before activations.
            S_W_LOAD: begin
                if (cnt_q < CNT_W'(col)) begin
                    inst_d.l0_rd = 1'b1;
                    inst_d.load  = 1'b1;
                end
                if (cnt_q == CNT_W'(col + 1)) begin
                    cnt_d   = '0;
                    state_d = S_A_L0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_A_L0: begin
                if (cnt_q < CNT_W'(len_nij)) begin
                    inst_d.cen_xmem = 1'b0;
                    inst_d.l0_wr    = 1'b1;
                    inst_d.a_xmem   = ADDR_W'(cnt_q);
                end
                if (cnt_q == CNT_W'(len_nij + 1)) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_EXEC: begin
                inst_d.l0_rd   = 1'b1;
                inst_d.execute = 1'b1;
                if (cnt_q == CNT_W'(len_nij - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Flush the array for row+col cycles, then one idle cycle.
            S_DRAIN: begin
                if (cnt_q < CNT_W'(row + col)) begin
                    inst_d.l0_rd   = 1'b1;
                    inst_d.execute = 1'b1;
                end
                if (cnt_q == CNT_W'(row + col)) begin
                    cnt_d   = '0;
                    state_d = S_O_PMEM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Move OFIFO rows to pmem; an empty OFIFO stalls without limit.
            S_O_PMEM: begin
                if (ofifo_valid) begin
                    inst_d.ofifo_rd = 1'b1;
                    inst_d.cen_pmem = 1'b0;
                    inst_d.wen_pmem = 1'b0;
                    inst_d.a_pmem   = wp_q;
                    wp_d            = wp_q + ADDR_W'(1);
                    if (cnt_q == CNT_W'(len_nij - 1)) begin
                        cnt_d   = '0;
                        state_d = S_NEXT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_NEXT: begin
                cnt_d = '0;
                if (kij_q < KIJ_W'(len_kij - 1)) begin
                    kij_d   = kij_q + KIJ_W'(1);
                    state_d = S_W_L0;
                end else begin
                    onij_d  = '0;
                    state_d = S_ACC_RD;
                end
            end

            // One pmem read per kernel position; acc trails the reads by one cycle.
            S_ACC_RD: begin
                if (cnt_q < CNT_W'(len_kij)) begin
                    inst_d.cen_pmem = 1'b0;
                    inst_d.a_pmem   = a_acc;
                end
                inst_d.acc = (cnt_q != '0);
                if (cnt_q == CNT_W'(len_kij)) begin
                    cnt_d   = '0;
                    state_d = S_ACC_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_ACC_GAP: begin
                cnt_d = '0;
                if (onij_q == ONIJ_W'(len_onij - 1)) begin
                    state_d = S_DONE;
                end else begin
                    onij_d  = onij_q + ONIJ_W'(1);
                    state_d = S_ACC_RD;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        done_d      = (state_q == S_DONE);
        out_valid_d = (state_q == S_ACC_GAP);
        onij_out_d  = onij_q;
    end

    assign inst      = inst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign onij      = onij_out_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: records whole runs and compares them with an instruction stream
// generated from the phase rules (weights, activations, execute, psum writes, accumulation).
module tb_inst_sequencer;

    localparam int unsigned COL  = 8;
    localparam int unsigned ROW  = 8;
    localparam int unsigned NIJ  = 36;
    localparam int unsigned KIJ  = 9;
    localparam int unsigned ONIJ = 16;

    typedef struct {
        logic [33:0] inst;
        logic        busy;
        logic        done;
        logic        ov;
        logic [3:0]  onij;
    } smp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic [3:0]  onij;

    smp_t        exp_q[$];
    smp_t        act_q[$];
    int          checks = 0;
    int          passes = 0;
    int          lows;
    bit          timed_out;
    bit          busy_after_start;
    logic [33:0] idle_w;

    always #5 clk = ~clk;

    inst_sequencer #(
        .col(COL), .row(ROW), .len_nij(NIJ), .len_kij(KIJ), .len_onij(ONIJ)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ofifo_valid(ofifo_valid),
        .inst(inst),
        .busy(busy),
        .done(done),
        .out_valid(out_valid),
        .onij(onij)
    );

    function automatic logic [33:0] mk(input logic acc, input logic cen_p, input logic wen_p,
                                       input int a_p, input logic cen_x, input logic wen_x,
                                       input int a_x, input logic ofr, input logic l0r,
                                       input logic l0w, input logic ex, input logic ld);
        logic [10:0] ap;
        logic [10:0] ax;
        ap = 11'(a_p);
        ax = 11'(a_x);
        return {acc, cen_p, wen_p, ap, cen_x, wen_x, ax, ofr, 1'b0, 1'b0, l0r, l0w, ex, ld};
    endfunction

    function automatic void push(input logic [33:0] w, input logic ov, input int o, input logic dn);
        smp_t s;
        s.inst = w;
        s.busy = !dn;
        s.done = dn;
        s.ov   = ov;
        s.onij = 4'(o);
        exp_q.push_back(s);
    endfunction

    // Expected cycle stream of an undisturbed run with the OFIFO always ready.
    function automatic void build_model();
        int wp;
        int a;
        exp_q.delete();
        wp = 0;
        for (int k = 0; k < int'(KIJ); k++) begin
            for (int c = 0; c < int'(COL); c++)
                push(mk(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1024 + k * int'(COL) + c,
                        1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 0, 1'b0);
            for (int c = 0; c < int'(COL); c++)
                push(mk(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, 0, 1'b0);
            for (int c = 0; c < 2; c++) push(idle_w, 1'b0, 0, 1'b0);
            for (int c = 0; c < int'(NIJ); c++)
                push(mk(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b0, 0, 1'b0);
            for (int c = 0; c < 2; c++) push(idle_w, 1'b0, 0, 1'b0);
            for (int c = 0; c < int'(NIJ + ROW + COL); c++)
                push(mk(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, 0, 1'b0);
            push(idle_w, 1'b0, 0, 1'b0);
            for (int c = 0; c < int'(NIJ); c++) begin
                push(mk(1'b0, 1'b0, 1'b0, wp, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 0, 1'b0);
                wp++;
            end
            push(idle_w, 1'b0, 0, 1'b0);
        end
        for (int o = 0; o < int'(ONIJ); o++) begin
            for (int j = 0; j <= int'(KIJ); j++) begin
                if (j < int'(KIJ)) begin
                    a = j * int'(NIJ) + (o / 4 + j / 3) * 6 + (o % 4) + (j % 3);
                    push(mk(j >= 1, 1'b0, 1'b1, a, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 0, 1'b0);
                end else begin
                    push(mk(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 0, 1'b0);
                end
            end
            push(idle_w, 1'b1, o, 1'b0);
        end
        push(idle_w, 1'b0, 0, 1'b1);
    endfunction

    // mode 0: OFIFO always ready; 1: 5-cycle stall after 10 writes plus a start during ACC_RD;
    // 2: random OFIFO readiness and random start pulses while busy.
    task automatic run_capture(input int mode);
        int  writes;
        int  ovs;
        int  low_left;
        int  tail;
        bit  stalled;
        act_q.delete();
        lows = 0;
        timed_out = 1'b0;
        writes = 0;
        ovs = 0;
        low_left = 0;
        tail = -1;
        stalled = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        busy_after_start = busy;
        start = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            smp_t s;
            @(negedge clk);
            s.inst = inst;
            s.busy = busy;
            s.done = done;
            s.ov   = out_valid;
            s.onij = onij;
            act_q.push_back(s);
            if (s.inst[6]) writes++;
            if (s.ov) ovs++;
            if (tail < 0 && s.done) tail = 4;
            else if (tail > 0) tail--;
            if (tail == 0) break;
            start = 1'b0;
            case (mode)
                1: begin
                    if (!stalled && writes == 10) begin
                        stalled = 1'b1;
                        low_left = 5;
                    end
                    if (low_left > 0) begin
                        ofifo_valid = 1'b0;
                        low_left--;
                    end else begin
                        ofifo_valid = 1'b1;
                    end
                    if (ovs == 6 && s.ov) start = 1'b1;
                end
                2: begin
                    ofifo_valid = ($urandom_range(0, 9) >= 3);
                    if (ovs < 15) start = ($urandom_range(0, 9) == 0);
                end
                default: ofifo_valid = 1'b1;
            endcase
            if (!ofifo_valid) lows++;
        end
        if (tail != 0) timed_out = 1'b1;
        start = 1'b0;
        ofifo_valid = 1'b1;
    endtask

    // Walk the recorded run against the model; an idle word where a psum write is due is a stall.
    task automatic compare_trace(input string tag, output int n_stall);
        int a;
        int e;
        a = 0;
        e = 0;
        n_stall = 0;
        while (a < 3 && a < act_q.size() && act_q[a].inst === idle_w && !act_q[a].done) a++;
        while (e < exp_q.size()) begin
            if (a >= act_q.size()) begin
                checks++;
                $display("FAIL %s trace_short: got %0d samples, required entry %0d of %0d",
                         tag, act_q.size(), e, exp_q.size());
                return;
            end
            if (exp_q[e].inst[6] && act_q[a].inst === idle_w && act_q[a].busy === 1'b1
                && act_q[a].ov === 1'b0 && act_q[a].done === 1'b0) begin
                n_stall++;
                a++;
            end else begin
                checks++;
                if (act_q[a].inst !== exp_q[e].inst)
                    $display("FAIL %s inst[%0d]: got %h required %h", tag, e, act_q[a].inst, exp_q[e].inst);
                else passes++;
                checks++;
                if ({act_q[a].busy, act_q[a].done, act_q[a].ov} !== {exp_q[e].busy, exp_q[e].done, exp_q[e].ov})
                    $display("FAIL %s busy_done_ov[%0d]: got %b required %b", tag, e,
                             {act_q[a].busy, act_q[a].done, act_q[a].ov},
                             {exp_q[e].busy, exp_q[e].done, exp_q[e].ov});
                else passes++;
                if (exp_q[e].ov) begin
                    checks++;
                    if (act_q[a].onij !== exp_q[e].onij)
                        $display("FAIL %s onij[%0d]: got %0d required %0d", tag, e, act_q[a].onij, exp_q[e].onij);
                    else passes++;
                end
                a++;
                e++;
            end
        end
        while (a < act_q.size()) begin
            checks++;
            if (act_q[a].inst !== idle_w || act_q[a].busy !== 1'b0 || act_q[a].done !== 1'b0)
                $display("FAIL %s after_done: got inst %h busy %b done %b required idle, 0, 0",
                         tag, act_q[a].inst, act_q[a].busy, act_q[a].done);
            else passes++;
            a++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (inst !== idle_w) $display("FAIL reset_inst: got %h required %h", inst, idle_w); else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passes++;
        checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b required 0", done); else passes++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else passes++;
        checks++;
        if (onij !== 4'd0) $display("FAIL reset_onij: got %0d required 0", onij); else passes++;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (inst !== idle_w || busy !== 1'b0)
            $display("FAIL idle_after_release: got inst %h busy %b required %h, 0", inst, busy, idle_w);
        else passes++;
    endtask

    task automatic test_full_run();
        int n_stall;
        int writes;
        int rd_idx[$];
        int r0;
        int exp5[9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};
        run_capture(0);
        checks++;
        if (busy_after_start !== 1'b1) $display("FAIL full_busy_rise: got %b required 1", busy_after_start);
        else passes++;
        checks++;
        if (timed_out) $display("FAIL full_timeout: got no done within budget, required done"); else passes++;
        compare_trace("full", n_stall);
        checks++;
        if (n_stall != 0) $display("FAIL full_stalls: got %0d required 0", n_stall); else passes++;
        writes = 0;
        foreach (act_q[i]) begin
            if (act_q[i].inst[6]) writes++;
            if (act_q[i].inst[32] === 1'b0 && act_q[i].inst[31] === 1'b1) rd_idx.push_back(i);
        end
        checks++;
        if (writes != int'(KIJ * NIJ)) $display("FAIL full_writes: got %0d required %0d", writes, KIJ * NIJ);
        else passes++;
        checks++;
        if (rd_idx.size() != int'(KIJ * ONIJ)) begin
            $display("FAIL full_reads: got %0d required %0d", rd_idx.size(), KIJ * ONIJ);
        end else begin
            passes++;
            for (int j = 0; j < 9; j++) begin
                checks++;
                if (act_q[rd_idx[45 + j]].inst[30:20] !== 11'(exp5[j]))
                    $display("FAIL onij5_addr[%0d]: got %0d required %0d", j, act_q[rd_idx[45 + j]].inst[30:20], exp5[j]);
                else passes++;
            end
            r0 = rd_idx[45];
            if (r0 + 10 < act_q.size()) begin
                for (int k = 0; k <= 10; k++) begin
                    checks++;
                    if (act_q[r0 + k].inst[33] !== ((k >= 1 && k <= 9) ? 1'b1 : 1'b0))
                        $display("FAIL onij5_acc[%0d]: got %b required %b", k, act_q[r0 + k].inst[33], (k >= 1 && k <= 9));
                    else passes++;
                end
            end
        end
    endtask

    task automatic test_stall();
        int n_stall;
        int i9;
        int i10;
        run_capture(1);
        checks++;
        if (timed_out) $display("FAIL stall_timeout: got no done within budget, required done"); else passes++;
        compare_trace("stall", n_stall);
        checks++;
        if (n_stall != 5) $display("FAIL stall_count: got %0d required 5", n_stall); else passes++;
        i9 = -1;
        i10 = -1;
        foreach (act_q[i]) begin
            if (act_q[i].inst[6] && act_q[i].inst[30:20] == 11'd9 && i9 < 0) i9 = i;
            if (act_q[i].inst[6] && act_q[i].inst[30:20] == 11'd10 && i10 < 0) i10 = i;
        end
        checks++;
        if (i10 - i9 - 1 != 5) $display("FAIL stall_gap: got %0d idle cycles between wp 9 and 10, required 5", i10 - i9 - 1);
        else passes++;
    endtask

    task automatic test_random();
        int n_stall;
        run_capture(2);
        checks++;
        if (timed_out) $display("FAIL random_timeout: got no done within budget, required done"); else passes++;
        compare_trace("random", n_stall);
        checks++;
        if (n_stall > lows) $display("FAIL random_stalls: got %0d required at most %0d", n_stall, lows);
        else passes++;
    endtask

    task automatic test_reset_mid_exec();
        bit seen_k3;
        bit seen_ex;
        bit quiet;
        int k;
        seen_k3 = 1'b0;
        seen_ex = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen_ex; cyc++) begin
            @(negedge clk);
            if (inst[2] && !inst[19] && inst[17:7] == 11'd1048) seen_k3 = 1'b1;
            if (seen_k3 && inst[1]) seen_ex = 1'b1;
        end
        checks++;
        if (!seen_ex) $display("FAIL rst_reach_exec_k3: got no kij 3 execute, required one"); else passes++;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (inst !== idle_w) $display("FAIL rst_mid_inst: got %h required %h", inst, idle_w); else passes++;
        checks++;
        if ({busy, done, out_valid} !== 3'b000)
            $display("FAIL rst_mid_flags: got %b required 000", {busy, done, out_valid});
        else passes++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (inst !== idle_w || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) $display("FAIL rst_no_resume: got activity after release, required idle"); else passes++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (inst === idle_w && k < 4) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < int'(COL); c++) begin
            checks++;
            if (inst !== mk(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1024 + c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0))
                $display("FAIL restart_wl0[%0d]: got %h required A_xmem %0d", c, inst, 1024 + c);
            else passes++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b1;
        idle_w = mk(1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        build_model();
        test_reset();
        test_full_run();
        test_stall();
        test_random();
        test_reset_mid_exec();
        reset = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
